kernel_scan_sequencer: RTL

KERNEL_SCAN_SEQUENCER -- requirements
Module: kernel_scan_sequencer

---
 rtl/kernel_scan_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/kernel_scan_sequencer.sv
// Zhang-Suen scan sequencer: walks the interior pixels two cycles each, two sub-iterations per pass.
// Optional pass limit enabled by defining SEQ_PASS_LIMIT_EN.
module kernel_scan_sequencer #(
    parameter int N        = 8,
    parameter int bitSize  = 6,
    parameter int MAX_PASS = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               changed_in,
    output logic [bitSize:0]   pixel_position_or_address,
    output logic               we,
    output logic               subiter,
    output logic               busy,
    output logic               done,
    output logic [3:0]         pass_count,
    output logic               limit_hit
);

    localparam int AW = bitSize + 1;
    localparam logic [AW-1:0] ONE  = AW'(1);
    localparam logic [AW-1:0] LAST = AW'(N - 2);
    localparam logic [AW-1:0] NW   = AW'(N);
    localparam logic [3:0]    MAXP = 4'(MAX_PASS);

`ifdef SEQ_PASS_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        HOLD,
        CHECK,
        DONE
    } state_t;

    state_t state, state_d;

    logic [AW-1:0] row, col, row_d, col_d;
    logic          subiter_d;
    logic          pass_changed, pass_changed_d;
    logic [3:0]    pass_count_d, cnt_inc;
    logic          limit_d;
    logic          last_pix;
    logic          we_d, busy_d, done_d;
    logic [AW-1:0] addr_d;

    assign last_pix = (row == LAST) && (col == LAST);
    assign cnt_inc  = (pass_count == 4'hF) ? 4'hF : pass_count + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d        = state;
        row_d          = row;
        col_d          = col;
        subiter_d      = subiter;
        pass_changed_d = pass_changed;
        pass_count_d   = pass_count;
        limit_d        = limit_hit;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d        = ISSUE;
                    row_d          = ONE;
                    col_d          = ONE;
                    subiter_d      = 1'b0;
                    pass_changed_d = 1'b0;
                    limit_d        = 1'b0;
                end
            end
            ISSUE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (changed_in) begin
                    pass_changed_d = 1'b1;
                end
                if (last_pix) begin
                    if (!subiter) begin
                        subiter_d = 1'b1;
                        row_d     = ONE;
                        col_d     = ONE;
                        state_d   = ISSUE;
                    end else begin
                        state_d = CHECK;
                    end
                end else begin
                    if (col == LAST) begin
                        col_d = ONE;
                        row_d = row + ONE;
                    end else begin
                        col_d = col + ONE;
                    end
                    state_d = ISSUE;
                end
            end
            CHECK: begin
                pass_count_d = cnt_inc;
                // A run that is still deleting pixels at the limit is cut off
                if (LIMIT_EN && (cnt_inc == MAXP) && pass_changed) begin
                    limit_d = 1'b1;
                    state_d = DONE;
                end else if (pass_changed) begin
                    pass_changed_d = 1'b0;
                    subiter_d      = 1'b0;
                    row_d          = ONE;
                    col_d          = ONE;
                    state_d        = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so they register alongside it
    always_comb begin
        we_d   = (state_d == ISSUE);
        busy_d = (state_d == ISSUE) || (state_d == HOLD) ||
                 (state_d == CHECK);
        done_d = (state_d == DONE);
        addr_d = pixel_position_or_address;
        if (state_d == ISSUE) begin
            addr_d = row_d * NW + col_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row                       <= ONE;
            col                       <= ONE;
            subiter                   <= 1'b0;
            pass_changed              <= 1'b0;
            pass_count                <= 4'd0;
            limit_hit                 <= 1'b0;
            pixel_position_or_address <= '0;
            we                        <= 1'b0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
        end else begin
            row                       <= row_d;
            col                       <= col_d;
            subiter                   <= subiter_d;
            pass_changed              <= pass_changed_d;
            pass_count                <= pass_count_d;
            limit_hit                 <= limit_d;
            pixel_position_or_address <= addr_d;
            we                        <= we_d;
            busy                      <= busy_d;
            done                      <= done_d;
        end
    end

endmodule
